// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage of the LoongArch CPU (between EX and WB).
//
// Holds one instruction. If it issued a data-SRAM request in EX, the stage
// waits for the in-order data_ok response. The response is buffered so a WB
// stall cannot lose it. Load data is aligned and sign/zero-extended before the
// payload goes to WB. On flush the instruction is dropped, and every response
// still in flight is counted so that it can be discarded when it arrives.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   mem_allowin        MEM can accept an instruction from EX this cycle
//   ex_to_mem_valid    EX presents a valid instruction
//   ex_to_mem_bus      [174:8] WB payload, [7] mem_req, [6:2] ld_op {b,bu,h,hu,w},
//                      [1:0] addr_lo
//   wb_allowin         WB can accept
//   mem_to_wb_valid    MEM presents a finished instruction
//   mem_to_wb_bus      WB payload, with rf_wdata replaced by the final load value
//   data_sram_data_ok  one-cycle response pulse, in request order
//   data_sram_rdata    response data, valid with data_ok
//   flush              wb_ex | ertn_flush from WB
//   mem_to_id_bus      {ld_blk, csr_blk, rf_we&valid, rf_waddr, rf_wdata}
//   mem_to_ex_bus      exception/ertn in MEM: EX must suppress stores
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int EX_BUS_W = 175,
   parameter int WB_BUS_W = 167
) (
   input  logic                clk,
   input  logic                resetn,
   output logic                mem_allowin,
   input  logic                ex_to_mem_valid,
   input  logic [EX_BUS_W-1:0] ex_to_mem_bus,
   input  logic                wb_allowin,
   output logic                mem_to_wb_valid,
   output logic [WB_BUS_W-1:0] mem_to_wb_bus,
   input  logic                data_sram_data_ok,
   input  logic [31:0]         data_sram_rdata,
   input  logic                flush,
   output logic [39:0]         mem_to_id_bus,
   output logic                mem_to_ex_bus
);

   logic                r_valid;
   logic [WB_BUS_W-1:0] r_payload;
   logic                r_mem_req;
   logic [4:0]          r_ld_op;
   logic [1:0]          r_addr_lo;
   logic                r_data_got;
   logic [31:0]         r_data_buf;
   logic [1:0]          r_discard_cnt;

   // Payload field views
   logic        w_rf_we;
   logic [4:0]  w_rf_waddr;
   logic [31:0] w_rf_wdata_in;
   logic        w_csr_re;
   logic        w_ertn_flush;
   logic        w_excep_en;

   assign w_rf_we       = r_payload[166];
   assign w_rf_waddr    = r_payload[165:161];
   assign w_rf_wdata_in = r_payload[160:129];
   assign w_csr_re      = r_payload[96];
   assign w_ertn_flush  = r_payload[16];
   assign w_excep_en    = r_payload[15];

   // A data_ok belongs to this instruction only when no older discarded
   // response is still outstanding.
   logic w_ok_live;
   logic w_ready_go;
   logic w_accept;
   logic w_capture;
   logic w_in_mem_req;

   assign w_ok_live    = data_sram_data_ok & (r_discard_cnt == 2'd0);
   assign w_ready_go   = ~r_mem_req | r_data_got | w_ok_live;
   assign mem_allowin  = ~r_valid | (w_ready_go & wb_allowin);
   assign w_accept     = ex_to_mem_valid & mem_allowin & ~flush;
   assign w_capture    = w_ok_live & r_valid & r_mem_req & ~r_data_got;
   assign w_in_mem_req = ex_to_mem_bus[7];

   // Load alignment / extension; the same-cycle response bypasses the buffer.
   logic [31:0] w_rdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_final;

   assign w_rdata = w_ok_live ? data_sram_rdata : r_data_buf;
   assign w_half  = r_addr_lo[1] ? w_rdata[31:16] : w_rdata[15:0];

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_byte  = w_rdata[7:0];
      w_final = w_rf_wdata_in;
      case (r_addr_lo)
         2'd1:    w_byte = w_rdata[15:8];
         2'd2:    w_byte = w_rdata[23:16];
         2'd3:    w_byte = w_rdata[31:24];
         default: w_byte = w_rdata[7:0];
      endcase
      if (r_mem_req && r_ld_op != 5'd0) begin
         if (r_ld_op[0])      w_final = w_rdata;
         else if (r_ld_op[4]) w_final = {{24{w_byte[7]}}, w_byte};
         else if (r_ld_op[3]) w_final = {24'd0, w_byte};
         else if (r_ld_op[2]) w_final = {{16{w_half[15]}}, w_half};
         else                 w_final = {16'd0, w_half};
      end
   end

   // Outstanding responses to drop. A data_ok first retires one discarded
   // response (or completes the current load), then a flush adds the current
   // load if it is still pending, plus the incoming instruction's request,
   // which EX has already issued by the time it presents the instruction.
   logic [2:0] w_disc_base;
   logic [2:0] w_disc_sum;
   logic       w_cur_pending;

   assign w_cur_pending = r_valid & r_mem_req & ~r_data_got & ~w_ok_live;
   assign w_disc_base   = (data_sram_data_ok && r_discard_cnt != 2'd0) ?
                          ({1'b0, r_discard_cnt} - 3'd1) : {1'b0, r_discard_cnt};
   assign w_disc_sum    = w_disc_base +
                          (flush ? ({2'd0, w_cur_pending} +
                                    {2'd0, ex_to_mem_valid & w_in_mem_req}) : 3'd0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid       <= 1'b0;
         r_payload     <= '0;
         r_mem_req     <= 1'b0;
         r_ld_op       <= 5'd0;
         r_addr_lo     <= 2'd0;
         r_data_got    <= 1'b0;
         r_data_buf    <= 32'd0;
         r_discard_cnt <= 2'd0;
      end else begin
         if (flush)            r_valid <= 1'b0;
         else if (mem_allowin) r_valid <= ex_to_mem_valid;

         if (w_accept) begin
            r_payload  <= ex_to_mem_bus[174:8];
            r_mem_req  <= ex_to_mem_bus[7];
            r_ld_op    <= ex_to_mem_bus[6:2];
            r_addr_lo  <= ex_to_mem_bus[1:0];
            r_data_got <= 1'b0;
         end else if (w_capture) begin
            r_data_buf <= data_sram_rdata;
            r_data_got <= 1'b1;
         end

         assert (w_disc_sum <= 3'd2)
            else $error("mem_stage: discard counter overflow");
         r_discard_cnt <= (w_disc_sum > 3'd3) ? 2'd3 : w_disc_sum[1:0];
      end
   end

   assign mem_to_wb_valid = r_valid & w_ready_go & ~flush;
   assign mem_to_wb_bus   = {r_payload[166:161], w_final, r_payload[128:0]};
   assign mem_to_ex_bus   = r_valid & (w_excep_en | w_ertn_flush);
   assign mem_to_id_bus   = {r_valid & r_mem_req & (r_ld_op != 5'd0) & ~w_ready_go,
                             r_valid & w_csr_re,
                             r_valid & w_rf_we,
                             w_rf_waddr,
                             w_final};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- directed vectors for mem_stage. Inputs change 1 ns after the
// rising edge; outputs are compared on the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_BU = 5'b01000;
   localparam logic [4:0] LD_H  = 5'b00100;
   localparam logic [4:0] LD_HU = 5'b00010;
   localparam logic [4:0] LD_W  = 5'b00001;
   localparam logic [4:0] NO_LD = 5'b00000;

   logic         clk = 1'b0;
   logic         resetn;
   logic         mem_allowin;
   logic         ex_to_mem_valid;
   logic [174:0] ex_to_mem_bus;
   logic         wb_allowin;
   logic         mem_to_wb_valid;
   logic [166:0] mem_to_wb_bus;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         flush;
   logic [39:0]  mem_to_id_bus;
   logic         mem_to_ex_bus;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .mem_allowin       (mem_allowin),
      .ex_to_mem_valid   (ex_to_mem_valid),
      .ex_to_mem_bus     (ex_to_mem_bus),
      .wb_allowin        (wb_allowin),
      .mem_to_wb_valid   (mem_to_wb_valid),
      .mem_to_wb_bus     (mem_to_wb_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .flush             (flush),
      .mem_to_id_bus     (mem_to_id_bus),
      .mem_to_ex_bus     (mem_to_ex_bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [174:0] mk(input logic rf_we, input logic [4:0] waddr,
                                       input logic [31:0] wdata, input logic excep,
                                       input logic ertn, input logic csr_re,
                                       input logic mem_req, input logic [4:0] ld_op,
                                       input logic [1:0] lo);
      logic [166:0] p;
      p = {rf_we, waddr, wdata, 32'h1c00_0100, csr_re, 1'b0, 14'd0, 32'd0, 32'd0,
           ertn, excep, 6'd0, 9'd0};
      return {p, mem_req, ld_op, lo};
   endfunction

   // advance to 1 ns after the next rising edge, inputs back to idle
   task automatic tick();
      @(posedge clk);
      #1;
      ex_to_mem_valid   = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'd0;
      flush             = 1'b0;
      wb_allowin        = 1'b1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [31:0] wb_wdata();
      return mem_to_wb_bus[160:129];
   endfunction

   // one load: presented for one cycle, response on the first cycle in MEM
   task automatic run_load(input string tag, input logic [4:0] op, input logic [1:0] lo,
                           input logic [31:0] rdata, input logic [31:0] exp);
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, op, lo);
      tick();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      sample();
      check({tag, "_valid"}, {63'd0, mem_to_wb_valid}, 64'd1);
      check({tag, "_wdata"}, {32'd0, wb_wdata()}, {32'd0, exp});
   endtask

   initial begin
      resetn            = 1'b0;
      ex_to_mem_valid   = 1'b0;
      ex_to_mem_bus     = '0;
      wb_allowin        = 1'b1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'd0;
      flush             = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      sample();
      check("rst_wb_valid", {63'd0, mem_to_wb_valid}, 64'd0);
      check("rst_ex_bus",   {63'd0, mem_to_ex_bus}, 64'd0);
      check("rst_id_bus",   {24'd0, mem_to_id_bus}, 64'd0);
      check("rst_allowin",  {63'd0, mem_allowin}, 64'd1);

      // add r5 <- 7: one cycle through MEM
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, NO_LD, 2'd0);
      tick();
      sample();
      check("add_valid",  {63'd0, mem_to_wb_valid}, 64'd1);
      check("add_id_bus", {24'd0, mem_to_id_bus}, {24'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'd7});
      check("add_wdata",  {32'd0, wb_wdata()}, 64'd7);
      tick();
      sample();
      check("add_drain",  {63'd0, mem_to_wb_valid}, 64'd0);

      // ld.w with data_ok on the third cycle in MEM
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      for (int k = 0; k < 2; k++) begin
         tick();
         sample();
         check("ldw_wait_valid", {63'd0, mem_to_wb_valid}, 64'd0);
         check("ldw_wait_blk",   {63'd0, mem_to_id_bus[39]}, 64'd1);
         check("ldw_wait_allow", {63'd0, mem_allowin}, 64'd0);
      end
      tick();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h8765_4321;
      sample();
      check("ldw_ok_valid", {63'd0, mem_to_wb_valid}, 64'd1);
      check("ldw_ok_wdata", {32'd0, wb_wdata()}, 64'h8765_4321);
      check("ldw_ok_blk",   {63'd0, mem_to_id_bus[39]}, 64'd0);
      check("ldw_ok_idw",   {32'd0, mem_to_id_bus[31:0]}, 64'h8765_4321);
      tick();
      sample();
      check("ldw_drain", {63'd0, mem_to_wb_valid}, 64'd0);

      // alignment and extension
      run_load("ldb3",  LD_B,  2'd3, 32'h8012_3456, 32'hFFFF_FF80);
      run_load("ldbu3", LD_BU, 2'd3, 32'h8012_3456, 32'h0000_0080);
      run_load("ldh2",  LD_H,  2'd2, 32'h8001_5678, 32'hFFFF_8001);
      run_load("ldhu2", LD_HU, 2'd2, 32'h8001_5678, 32'h0000_8001);
      run_load("ldb1",  LD_B,  2'd1, 32'h0000_F500, 32'hFFFF_FFF5);
      run_load("ldh0",  LD_H,  2'd0, 32'h1234_7FFF, 32'h0000_7FFF);

      // WB stalled when the response arrives: buffered value is held
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      tick();
      wb_allowin        = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_1234;
      sample();
      check("stall_ok_allow", {63'd0, mem_allowin}, 64'd0);
      for (int k = 0; k < 2; k++) begin
         tick();
         wb_allowin = 1'b0;
         sample();
         check("stall_hold_allow", {63'd0, mem_allowin}, 64'd0);
         check("stall_hold_wdata", {32'd0, wb_wdata()}, 64'h1234);
      end
      tick();
      sample();
      check("stall_open_valid", {63'd0, mem_to_wb_valid}, 64'd1);
      check("stall_open_wdata", {32'd0, wb_wdata()}, 64'h1234);
      check("stall_open_allow", {63'd0, mem_allowin}, 64'd1);

      // flush with a waiting load and an issued load entering: two responses dropped
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd6, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      flush           = 1'b1;
      sample();
      check("flush_wb_valid", {63'd0, mem_to_wb_valid}, 64'd0);
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      sample();
      check("flush_empty_allow", {63'd0, mem_allowin}, 64'd1);
      for (int k = 0; k < 2; k++) begin
         tick();
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = 32'hDEAD_0000 + k;
         sample();
         check("discard_valid", {63'd0, mem_to_wb_valid}, 64'd0);
         check("discard_blk",   {63'd0, mem_to_id_bus[39]}, 64'd1);
      end
      tick();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0C0C_0C0C;
      sample();
      check("after_discard_valid", {63'd0, mem_to_wb_valid}, 64'd1);
      check("after_discard_wdata", {32'd0, wb_wdata()}, 64'h0C0C_0C0C);

      // exception and ertn reach EX
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, NO_LD, 2'd0);
      tick();
      wb_allowin = 1'b0;
      sample();
      check("excep_ex_bus", {63'd0, mem_to_ex_bus}, 64'd1);
      check("excep_valid",  {63'd0, mem_to_wb_valid}, 64'd1);
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, NO_LD, 2'd0);
      tick();
      sample();
      check("ertn_ex_bus",  {63'd0, mem_to_ex_bus}, 64'd1);
      check("csr_blk",      {63'd0, mem_to_id_bus[38]}, 64'd1);
      tick();
      sample();
      check("ex_bus_clear", {63'd0, mem_to_ex_bus}, 64'd0);

      // reset mid-wait, after a flush left one response pending
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      tick();
      flush = 1'b1;
      tick();
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = mk(1'b1, 5'd11, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0);
      tick();
      sample();
      check("rst_pre_blk", {63'd0, mem_to_id_bus[39]}, 64'd1);
      tick();
      resetn = 1'b0;
      tick();
      sample();
      check("rst_mid_wb_valid", {63'd0, mem_to_wb_valid}, 64'd0);
      check("rst_mid_ex_bus",   {63'd0, mem_to_ex_bus}, 64'd0);
      check("rst_mid_id_bus",   {24'd0, mem_to_id_bus}, 64'd0);
      resetn = 1'b1;
      run_load("post_rst", LD_W, 2'd0, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
